// File: rtl/display_mux_0_99_pkg.sv
// rtl/display_mux_0_99_pkg.sv - segment patterns, slot encoding and digit-enable constants
package display_mux_0_99_pkg;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    typedef enum logic {
        UNI = 1'b0,
        TEN = 1'b1
    } slot_t;

    localparam logic [1:0] DIG_UNI = 2'b10;
    localparam logic [1:0] DIG_TEN = 2'b01;
    localparam logic [1:0] DIG_OFF = 2'b11;

    function automatic logic is_bcd_err(input logic [3:0] d);
        return d > 4'd9;
    endfunction

endpackage

// File: rtl/display_mux_0_99_bcd_para_7seg.sv
// rtl/display_mux_0_99_bcd_para_7seg.sv - combinational BCD to active-low seven-segment decoder
module bcd_para_7seg
    import display_mux_0_99_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/display_mux_0_99.sv
// rtl/display_mux_0_99.sv - two-digit multiplexed seven-segment driver; DISPLAY_BLANK_ZERO_EN enables leading-zero blanking
module display_mux_0_99
    import display_mux_0_99_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 25
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] units,
    input  logic [3:0] tens,
    input  logic       upd,
    input  logic       blink,
    output logic [6:0] seg,
    output logic [1:0] dig_n,
    output logic       bcd_err
);

    localparam int             PW     = $clog2(SCAN_DIV);
    localparam logic [PW-1:0]  P_LAST = PW'(SCAN_DIV - 1);
    localparam int             BW     = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0]  B_LAST = BW'(BLINK_DIV - 1);

    logic [3:0]    r_units;
    logic [3:0]    r_tens;
    logic [PW-1:0] r_presc;
    slot_t         r_slot;
    logic [BW-1:0] r_bcnt;
    logic          r_phase;

    logic       w_wrap;
    logic       w_blank;
    logic       w_lead_blank;
    logic [3:0] w_digit;
    logic [6:0] w_seg;

    assign w_wrap  = (r_presc == P_LAST);
    assign w_digit = (r_slot == TEN) ? r_tens : r_units;
    // Gating with the live blink input lets the display reappear on the first edge after blink drops.
    assign w_blank = blink & r_phase;

`ifdef DISPLAY_BLANK_ZERO_EN
    assign w_lead_blank = (r_tens == 4'd0);
`else
    assign w_lead_blank = 1'b0;
`endif

    bcd_para_7seg u_dec (
        .i_bcd (w_digit),
        .o_seg (w_seg)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_units <= 4'd0;
            r_tens  <= 4'd0;
            r_presc <= '0;
            r_slot  <= UNI;
            r_bcnt  <= '0;
            r_phase <= 1'b0;
            seg     <= SEG_0;
            dig_n   <= DIG_UNI;
            bcd_err <= 1'b0;
        end else begin
            if (upd) begin
                r_units <= units;
                r_tens  <= tens;
            end

            if (w_wrap) begin
                r_presc <= '0;
                r_slot  <= (r_slot == UNI) ? TEN : UNI;
            end else begin
                r_presc <= r_presc + PW'(1);
            end

            if (!blink) begin
                r_bcnt  <= '0;
                r_phase <= 1'b0;
            end else if (w_wrap) begin
                if (r_bcnt == B_LAST) begin
                    r_bcnt  <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_bcnt  <= r_bcnt + BW'(1);
                end
            end

            bcd_err <= is_bcd_err(r_units) | is_bcd_err(r_tens);

            // Enable and pattern are always taken from the same slot so they switch together.
            if (w_blank || (r_slot == TEN && w_lead_blank)) begin
                seg   <= SEG_OFF;
                dig_n <= DIG_OFF;
            end else if (r_slot == TEN) begin
                seg   <= w_seg;
                dig_n <= DIG_TEN;
            end else begin
                seg   <= w_seg;
                dig_n <= DIG_UNI;
            end
        end
    end

endmodule
